// File: rtl/sram_pkg.sv
// Shared types, limits and the byte-lane merge helper for the SRAM controller.
package sram_pkg;

  localparam int RD_LATENCY_MAX = 4;
  localparam int MERGE_W_MAX    = 256;

  typedef enum logic {ST_CLEAR, ST_RUN} sram_state_e;

  // Returns old with every lane whose enable bit is set replaced by the
  // matching lane of wdata. Operands are zero-extended to MERGE_W_MAX bits
  // so one helper serves every word width the controller may be built with.
  function automatic logic [MERGE_W_MAX-1:0] be_merge(
    input logic [MERGE_W_MAX-1:0] old,
    input logic [MERGE_W_MAX-1:0] wdata,
    input logic [MERGE_W_MAX-1:0] be,
    input int                     byteW
  );
    logic [MERGE_W_MAX-1:0] merged;
    logic [7:0]             lane;
    merged = old;
    for (int i = 0; i < MERGE_W_MAX; i++) begin
      lane = 8'(i / byteW);
      if (be[lane]) merged[i] = wdata[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_rsp_pipe.sv
// Fixed-latency response pipe: one valid+data stage per cycle of latency plus
// the capture stage loaded on the accept edge. Valid bits clear asynchronously
// so in-flight responses are dropped on reset; data stages only advance behind
// a valid bit, so the output word holds its last response while idle.
module sram_rsp_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  localparam int STAGES = RD_LATENCY + 1;

  logic [STAGES-1:0]     vld_q;
  logic [DATA_WIDTH-1:0] dat_q [STAGES];

  // Shift valid bits every cycle and move data only where a response travels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= {vld_q[STAGES-2:0], in_valid_i};
      if (in_valid_i) dat_q[0] <= in_data_i;
      for (int k = 1; k < STAGES; k++) begin
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign out_valid_o = vld_q[STAGES-1];
  assign out_data_o  = dat_q[STAGES-1];

endmodule

// File: rtl/sram_be_pipe_ctrl.sv
// Single-port SRAM model with byte enables, valid/ready requests, a
// fixed-latency response pipe, read-first or write-through write responses
// and an optional zero-fill of the whole array after reset.
module sram_be_pipe_ctrl
  import sram_pkg::*;
#(
  parameter int  DATA_WIDTH     = 32,
  parameter int  ADDR_WIDTH     = 4,
  parameter int  BYTE_W         = 8,
  parameter int  RD_LATENCY     = 2,
  parameter int  READ_FIRST     = 1,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int NUM_BYTES      = DATA_WIDTH / BYTE_W,
  localparam int DEPTH          = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_BYTES-1:0]  req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done
);

  if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH > MERGE_W_MAX) begin : g_bad_width
    $error("sram_be_pipe_ctrl: DATA_WIDTH must be a multiple of BYTE_W and at most MERGE_W_MAX");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("sram_be_pipe_ctrl: RD_LATENCY must lie in 1..RD_LATENCY_MAX");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clrAddr_q, clrAddr_d;
  logic                  clrWe;
  logic                  running;
  logic                  accept;
  logic [DATA_WIDTH-1:0] oldWord;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [DATA_WIDTH-1:0] rspWord;
  logic [MERGE_W_MAX-1:0] oldExt, wdataExt, beExt;

  // Clear walks the array one word per cycle; run state accepts requests.
  // Outputs are gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    state_d   = state_q;
    clrAddr_d = clrAddr_q;
    clrWe     = 1'b0;
    running   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clrWe     = rst_n;
        clrAddr_d = clrAddr_q + 1'b1;
        if (clrAddr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        running = rst_n;
      end
    endcase
  end

  // State and clear address registers; reset restarts any clear from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clrAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      clrAddr_q <= clrAddr_d;
    end
  end

  assign req_ready = running;
  assign init_done = running;
  assign accept    = req_valid & running;
  assign oldWord   = mem_q[req_addr];

  // Byte-lane merge of the addressed word and choice of the response word.
  always_comb begin
    oldExt   = '0;
    wdataExt = '0;
    beExt    = '0;
    oldExt[DATA_WIDTH-1:0]   = oldWord;
    wdataExt[DATA_WIDTH-1:0] = req_wdata;
    beExt[NUM_BYTES-1:0]     = req_be;
    mergedWord = DATA_WIDTH'(be_merge(oldExt, wdataExt, beExt, BYTE_W));
    rspWord    = (req_we && READ_FIRST == 0) ? mergedWord : oldWord;
  end

  // Array write port, shared between the clear sweep and accepted writes.
  always_ff @(posedge clk) begin
    if (clrWe) begin
      mem_q[clrAddr_q] <= '0;
    end else if (accept && req_we) begin
      mem_q[req_addr] <= mergedWord;
    end
  end

  sram_rsp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LATENCY(RD_LATENCY)
  ) uRspPipe (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (accept),
    .in_data_i  (rspWord),
    .out_valid_o(rsp_valid),
    .out_data_o (rsp_rdata)
  );

endmodule

// File: tb/tb_sram_be_pipe_ctrl.sv
// Bench for sram_be_pipe_ctrl: five instances share one request stream and
// differ in latency, write-response mode and clear behaviour. A word-level
// model predicts, per instance, which cycle carries each response and its data.
module tb_sram_be_pipe_ctrl;

  localparam int NDUT    = 5;
  localparam int HORIZON = 4096;
  localparam int LAT_TAB [NDUT] = '{2, 2, 1, 4, 2};
  localparam int RF_TAB  [NDUT] = '{1, 0, 1, 1, 1};
  localparam int CLR_TAB [NDUT] = '{1, 1, 1, 1, 0};

  logic        clk;
  logic        rst_n;
  logic        reqValid;
  logic        reqWe;
  logic [3:0]  reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqBe;

  logic [NDUT-1:0] reqReady;
  logic [NDUT-1:0] rspValid;
  logic [NDUT-1:0] initDone;
  logic [31:0]     rspData [NDUT];

  bit          expValid [NDUT][HORIZON];
  logic [31:0] expData  [NDUT][HORIZON];
  logic [31:0] modelMem [16];
  int          cyc;
  int          clrCount;
  bit          modelReady;
  bit          inReset;
  int          checks;
  int          failures;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sram_be_pipe_ctrl #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (4),
      .BYTE_W        (8),
      .RD_LATENCY    (LAT_TAB[g]),
      .READ_FIRST    (RF_TAB[g]),
      .CLEAR_ON_RESET(CLR_TAB[g])
    ) uDut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(reqValid),
      .req_ready(reqReady[g]),
      .req_we   (reqWe),
      .req_addr (reqAddr),
      .req_wdata(reqWdata),
      .req_be   (reqBe),
      .rsp_valid(rspValid[g]),
      .rsp_rdata(rspData[g]),
      .init_done(initDone[g])
    );
  end

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic expRdy;
    for (int k = 0; k < NDUT; k++) begin
      expRdy = (CLR_TAB[k] != 0) ? modelReady : !inReset;
      checkValue($sformatf("cyc%0d dut%0d req_ready", cyc, k), {31'b0, reqReady[k]}, {31'b0, expRdy});
      checkValue($sformatf("cyc%0d dut%0d init_done", cyc, k), {31'b0, initDone[k]}, {31'b0, expRdy});
      if (CLR_TAB[k] != 0) begin
        checkValue($sformatf("cyc%0d dut%0d rsp_valid", cyc, k), {31'b0, rspValid[k]},
                   {31'b0, expValid[k][cyc]});
        if (expValid[k][cyc])
          checkValue($sformatf("cyc%0d dut%0d rsp_rdata", cyc, k), rspData[k], expData[k][cyc]);
      end
    end
  endtask

  // Drive one request at the falling edge, advance the model at the rising
  // edge, then check every instance at the next falling edge.
  task automatic applyStimulus(input logic v, input logic we, input logic [3:0] addr,
                               input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] oldW;
    logic [31:0] newW;
    reqValid = v;
    reqWe    = we;
    reqAddr  = addr;
    reqWdata = wd;
    reqBe    = be;
    @(posedge clk);
    cyc++;
    if (v && modelReady && !inReset) begin
      oldW = modelMem[addr];
      newW = oldW;
      for (int b = 0; b < 4; b++) if (be[b]) newW[8*b +: 8] = wd[8*b +: 8];
      for (int k = 0; k < NDUT; k++) begin
        expValid[k][cyc + LAT_TAB[k]] = 1'b1;
        expData[k][cyc + LAT_TAB[k]]  = (we && RF_TAB[k] == 0) ? newW : oldW;
      end
      if (we) modelMem[addr] = newW;
    end else if (!modelReady && !inReset) begin
      clrCount++;
      if (clrCount == 16) modelReady = 1'b1;
    end
    @(negedge clk);
    checkOutput();
  endtask

  // Assert reset at a falling edge with outputs checked straight away, hold it
  // for lowCycles rising edges, then release; pending responses are forgotten.
  task automatic applyReset(input int lowCycles);
    rst_n      = 1'b0;
    inReset    = 1'b1;
    modelReady = 1'b0;
    clrCount   = 0;
    for (int k = 0; k < NDUT; k++)
      for (int t = cyc; t < HORIZON; t++) expValid[k][t] = 1'b0;
    #1;
    checkOutput();
    checkValue("reset rsp_rdata", rspData[0], 32'h0);
    @(negedge clk);
    for (int i = 0; i < lowCycles; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    rst_n   = 1'b1;
    inReset = 1'b0;
    for (int a = 0; a < 16; a++) modelMem[a] = 32'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    clrCount = 0;
    modelReady = 1'b0;
    inReset    = 1'b0;
    rst_n    = 1'b1;
    reqValid = 1'b0;
    reqWe    = 1'b0;
    reqAddr  = 4'h0;
    reqWdata = 32'h0;
    reqBe    = 4'h0;
    @(negedge clk);

    $display("[TB] reset release and clear sweep, requests held while not ready");
    applyReset(3);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b1, 4'(i), 32'hDEAD0000 | 32'(i), 4'hF);

    $display("[TB] read every word after the clear");
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

    $display("[TB] full and partial byte-enable writes");
    applyStimulus(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'hF);
    applyStimulus(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 4'd3, 32'h11223344, 4'b0101);
    applyStimulus(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 4'd3, 32'hFFFFFFFF, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

    $display("[TB] back-to-back write then reads");
    applyStimulus(1'b1, 1'b1, 4'd5, 32'h00000005, 4'hF);
    applyStimulus(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'd6, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

    $display("[TB] reset with reads in flight, then reset during the clear");
    applyStimulus(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    applyReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    applyReset(1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom, 4'($urandom));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
